// File: rtl/fixed_linear_act_pkg.sv
// Shared types and helpers for the fused linear + activation block.
package fixed_linear_act_pkg;

  localparam int ACT_NONE  = 0;
  localparam int ACT_RELU  = 1;
  localparam int ACT_LEAKY = 2;

  typedef enum logic [1:0] {LOAD, ACCUM, EMIT} state_t;

  // Accumulator sized so a full dot product plus aligned bias cannot overflow.
  function automatic int acc_width(input int di_w, input int w_w, input int in_size);
    return di_w + w_w + $clog2(in_size) + 1;
  endfunction

endpackage

// File: rtl/fixed_cast_act.sv
// One output element: round/truncate, saturate, then apply the activation.
module fixed_cast_act
  import fixed_linear_act_pkg::*;
#(
  parameter int ACC_W       = 20,
  parameter int IN_F        = 6,
  parameter int DO_W        = 8,
  parameter int DO_F        = 3,
  parameter int ACT_MODE    = ACT_RELU,
  parameter int LEAKY_SHIFT = 3,
  parameter int ROUND       = 1
) (
  input  logic signed [ACC_W-1:0] acc_i,
  output logic        [DO_W-1:0]  y_o
);

  localparam int SH = IN_F - DO_F;
  localparam int RW = ACC_W + 1;
  localparam logic signed [RW-1:0] HALF =
    (ROUND != 0 && SH > 0) ? (RW'(1) <<< ((SH > 0) ? SH - 1 : 0)) : '0;
  localparam logic signed [RW-1:0] MAXV = RW'((64'sd1 <<< (DO_W - 1)) - 64'sd1);
  localparam logic signed [RW-1:0] MINV = ~MAXV;

  logic signed [RW-1:0]   rnd, shf;
  logic signed [DO_W-1:0] sat;

  // Extra headroom bit keeps the half-LSB add from wrapping at the top of range.
  always_comb begin
    rnd = $signed({acc_i[ACC_W-1], acc_i}) + HALF;
    shf = rnd >>> SH;
    if (shf > MAXV)      sat = MAXV[DO_W-1:0];
    else if (shf < MINV) sat = MINV[DO_W-1:0];
    else                 sat = shf[DO_W-1:0];
    case (ACT_MODE)
      ACT_RELU:  y_o = sat[DO_W-1] ? '0 : sat;
      ACT_LEAKY: y_o = sat[DO_W-1] ? (sat >>> LEAKY_SHIFT) : sat;
      default:   y_o = sat;
    endcase
  end

endmodule

// File: rtl/fixed_linear_act.sv
// Streaming fully-connected layer: buffer one input vector, replay it
// against weight blocks per output group, add bias, cast and activate.
module fixed_linear_act
  import fixed_linear_act_pkg::*;
#(
  parameter int DATA_IN_0_PRECISION_0        = 8,
  parameter int DATA_IN_0_PRECISION_1        = 3,
  parameter int DATA_IN_0_TENSOR_SIZE_DIM_0  = 8,
  parameter int DATA_IN_0_PARALLELISM_DIM_0  = 4,
  parameter int WEIGHT_PRECISION_0           = 8,
  parameter int WEIGHT_PRECISION_1           = 3,
  parameter int BIAS_PRECISION_0             = 8,
  parameter int BIAS_PRECISION_1             = 3,
  parameter int DATA_OUT_0_PRECISION_0       = 8,
  parameter int DATA_OUT_0_PRECISION_1       = 3,
  parameter int DATA_OUT_0_TENSOR_SIZE_DIM_0 = 8,
  parameter int DATA_OUT_0_PARALLELISM_DIM_0 = 4,
  parameter int ACT_MODE                     = ACT_RELU,
  parameter int LEAKY_SHIFT                  = 3,
  parameter int ROUND                        = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic [DATA_IN_0_PARALLELISM_DIM_0-1:0][DATA_IN_0_PRECISION_0-1:0] data_in_0,
  input  logic data_in_0_valid,
  output logic data_in_0_ready,
  input  logic [DATA_IN_0_PARALLELISM_DIM_0*DATA_OUT_0_PARALLELISM_DIM_0-1:0][WEIGHT_PRECISION_0-1:0] weight,
  input  logic weight_valid,
  output logic weight_ready,
  input  logic [DATA_OUT_0_PARALLELISM_DIM_0-1:0][BIAS_PRECISION_0-1:0] bias,
  input  logic bias_valid,
  output logic bias_ready,
  output logic [DATA_OUT_0_PARALLELISM_DIM_0-1:0][DATA_OUT_0_PRECISION_0-1:0] data_out_0,
  output logic data_out_0_valid,
  input  logic data_out_0_ready
);

  localparam int DI_W = DATA_IN_0_PRECISION_0;
  localparam int DI_F = DATA_IN_0_PRECISION_1;
  localparam int W_W  = WEIGHT_PRECISION_0;
  localparam int W_F  = WEIGHT_PRECISION_1;
  localparam int B_F  = BIAS_PRECISION_1;
  localparam int DO_W = DATA_OUT_0_PRECISION_0;
  localparam int DO_F = DATA_OUT_0_PRECISION_1;
  localparam int IN_SIZE   = DATA_IN_0_TENSOR_SIZE_DIM_0;
  localparam int IN_PAR    = DATA_IN_0_PARALLELISM_DIM_0;
  localparam int OUT_SIZE  = DATA_OUT_0_TENSOR_SIZE_DIM_0;
  localparam int OUT_PAR   = DATA_OUT_0_PARALLELISM_DIM_0;
  localparam int IN_DEPTH  = IN_SIZE / IN_PAR;
  localparam int OUT_DEPTH = OUT_SIZE / OUT_PAR;
  localparam int P_W   = DI_W + W_W;
  localparam int P_F   = DI_F + W_F;
  localparam int BSH   = P_F - B_F;
  localparam int ACC_W = acc_width(DI_W, W_W, IN_SIZE);
  localparam int ICW   = (IN_DEPTH > 1) ? $clog2(IN_DEPTH) : 1;
  localparam int OCW   = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;
  localparam logic [ICW-1:0] IN_LAST  = ICW'(IN_DEPTH - 1);
  localparam logic [OCW-1:0] OUT_LAST = OCW'(OUT_DEPTH - 1);

  if (IN_SIZE % IN_PAR != 0) begin : g_err_in
    $error("IN_SIZE must be a multiple of IN_PAR");
  end
  if (OUT_SIZE % OUT_PAR != 0) begin : g_err_out
    $error("OUT_SIZE must be a multiple of OUT_PAR");
  end
  if (BSH < 0) begin : g_err_bias
    $error("bias fraction exceeds product fraction");
  end
  if (P_F < DO_F) begin : g_err_cast
    $error("output fraction exceeds product fraction");
  end

  state_t                                  state_q, state_d;
  logic [ICW-1:0]                          in_cnt_q, in_cnt_d;
  logic [OCW-1:0]                          out_cnt_q, out_cnt_d;
  logic                                    din_rdy_q;
  logic [IN_DEPTH-1:0][IN_PAR-1:0][DI_W-1:0] vbuf_q;
  logic [IN_PAR-1:0][DI_W-1:0]             cur;
  logic [OUT_PAR-1:0][ACC_W-1:0]           acc_q, sum_d;
  logic [OUT_PAR-1:0][DO_W-1:0]            dout_q, cast_d;
  logic                                    last_beat, din_fire, w_fire, dout_fire;

  assign last_beat        = (in_cnt_q == IN_LAST);
  assign cur              = vbuf_q[in_cnt_q];
  assign data_in_0_ready  = din_rdy_q;
  assign din_fire         = din_rdy_q && data_in_0_valid;
  // On the last beat weight and bias must move together, so each ready
  // waits on the other side's valid.
  assign weight_ready     = (state_q == ACCUM) && (!last_beat || bias_valid);
  assign bias_ready       = (state_q == ACCUM) && last_beat && weight_valid;
  assign w_fire           = weight_valid && weight_ready;
  assign data_out_0_valid = (state_q == EMIT);
  assign dout_fire        = data_out_0_valid && data_out_0_ready;
  assign data_out_0       = dout_q;

  // Partial dot product for this beat; bias joins only on the last beat.
  always_comb begin
    for (int o = 0; o < OUT_PAR; o++) begin
      sum_d[o] = acc_q[o];
      for (int i = 0; i < IN_PAR; i++)
        sum_d[o] = sum_d[o] + ACC_W'(P_W'($signed(cur[i])) * P_W'($signed(weight[o*IN_PAR+i])));
      if (last_beat)
        sum_d[o] = sum_d[o] + (ACC_W'($signed(bias[o])) <<< BSH);
    end
  end

  for (genvar o = 0; o < OUT_PAR; o++) begin : g_cast
    fixed_cast_act #(
      .ACC_W(ACC_W), .IN_F(P_F), .DO_W(DO_W), .DO_F(DO_F),
      .ACT_MODE(ACT_MODE), .LEAKY_SHIFT(LEAKY_SHIFT), .ROUND(ROUND)
    ) u_cast (
      .acc_i(sum_d[o]),
      .y_o  (cast_d[o])
    );
  end

  // Next-state and counter updates.
  always_comb begin
    state_d   = state_q;
    in_cnt_d  = in_cnt_q;
    out_cnt_d = out_cnt_q;
    case (state_q)
      LOAD: if (din_fire) begin
        if (last_beat) begin
          in_cnt_d  = '0;
          out_cnt_d = '0;
          state_d   = ACCUM;
        end else in_cnt_d = in_cnt_q + ICW'(1);
      end
      ACCUM: if (w_fire) begin
        if (last_beat) begin
          in_cnt_d = '0;
          state_d  = EMIT;
        end else in_cnt_d = in_cnt_q + ICW'(1);
      end
      EMIT: if (dout_fire) begin
        in_cnt_d = '0;
        if (out_cnt_q == OUT_LAST) begin
          out_cnt_d = '0;
          state_d   = LOAD;
        end else begin
          out_cnt_d = out_cnt_q + OCW'(1);
          state_d   = ACCUM;
        end
      end
      default: state_d = LOAD;
    endcase
  end

  // Control registers; input ready is registered off the next state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= LOAD;
      in_cnt_q  <= '0;
      out_cnt_q <= '0;
      din_rdy_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      in_cnt_q  <= in_cnt_d;
      out_cnt_q <= out_cnt_d;
      din_rdy_q <= (state_d == LOAD);
    end
  end

  // Vector buffer, accumulators and the held output block.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vbuf_q <= '0;
      acc_q  <= '0;
      dout_q <= '0;
    end else begin
      if (din_fire) vbuf_q[in_cnt_q] <= data_in_0;
      if (w_fire) begin
        if (last_beat) begin
          acc_q  <= '0;
          dout_q <= cast_d;
        end else acc_q <= sum_d;
      end
    end
  end

endmodule

// File: tb/tb_fixed_linear_act.sv
// Scoreboard bench: three instances (relu/round, none/truncate, leaky/round)
// share stimulus; each has its own expected-output queue.
module tb_fixed_linear_act;
  import fixed_linear_act_pkg::*;

  localparam int IN_DEPTH  = 2;
  localparam int OUT_DEPTH = 2;
  localparam int NI = 3;

  logic clk = 1'b0;
  logic rst;
  logic [3:0][7:0]  data_in_0;
  logic             data_in_0_valid;
  logic [15:0][7:0] weight;
  logic             weight_valid;
  logic [3:0][7:0]  bias;
  logic             bias_valid;
  logic             out_rdy;

  logic [3:0][7:0] dout [NI];
  logic dval [NI], drdy [NI], wrdy [NI], brdy [NI];

  logic [31:0] expq [NI][$];
  int checks = 0, failures = 0;
  int nd = 0, nw = 0;

  always #5 clk = ~clk;

  for (genvar m = 0; m < NI; m++) begin : g_dut
    fixed_linear_act #(
      .ACT_MODE   ((m == 0) ? ACT_RELU : ((m == 1) ? ACT_NONE : ACT_LEAKY)),
      .LEAKY_SHIFT(3),
      .ROUND      ((m == 1) ? 0 : 1)
    ) u_dut (
      .clk(clk), .rst(rst),
      .data_in_0(data_in_0), .data_in_0_valid(data_in_0_valid), .data_in_0_ready(drdy[m]),
      .weight(weight), .weight_valid(weight_valid), .weight_ready(wrdy[m]),
      .bias(bias), .bias_valid(bias_valid), .bias_ready(brdy[m]),
      .data_out_0(dout[m]), .data_out_0_valid(dval[m]), .data_out_0_ready(out_rdy)
    );
  end

  // Monitor: a beat that is valid and ready mid-cycle transfers at the next edge.
  always @(negedge clk) begin
    #2;
    if (data_in_0_valid && drdy[0]) nd++;
    if (weight_valid && wrdy[0]) nw++;
    for (int m = 0; m < NI; m++) begin
      if (dval[m] && out_rdy) begin
        checks++;
        if (expq[m].size() == 0) begin
          failures++;
          $display("FAIL out%0d unexpected beat got=%h", m, dout[m]);
        end else begin
          logic [31:0] e;
          e = expq[m].pop_front();
          if (dout[m] !== e) begin
            failures++;
            $display("FAIL out%0d got=%h exp=%h", m, dout[m], e);
          end
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
    end
  endtask

  // Entered at a negedge with the beat driven; returns at the negedge after transfer.
  task automatic xfer(input int sel, input string nm);
    int n = 0;
    #1;
    while (!((sel == 0) ? drdy[0] : wrdy[0])) begin
      @(negedge clk); #1;
      n++;
      if (n > 200) begin
        checks++; failures++;
        $display("FAIL timeout %s", nm);
        break;
      end
    end
    @(negedge clk);
  endtask

  task automatic send_vec(input logic [7:0] d);
    for (int k = 0; k < IN_DEPTH; k++) begin
      data_in_0 = {4{d}};
      data_in_0_valid = 1'b1;
      xfer(0, "din");
    end
    data_in_0_valid = 1'b0;
  endtask

  task automatic send_wbeat(input int k, input logic [7:0] w, input bit l0, input logic [7:0] b);
    for (int j = 0; j < 16; j++)
      weight[j] = (!l0 || (k == 0 && j % 4 == 0)) ? w : 8'h00;
    bias = {4{b}};
    bias_valid = (k == IN_DEPTH - 1);
    weight_valid = 1'b1;
    xfer(1, "wt");
    weight_valid = 1'b0;
    bias_valid = 1'b0;
  endtask

  task automatic send_group(input logic [7:0] w, input bit l0, input logic [7:0] b);
    for (int k = 0; k < IN_DEPTH; k++) send_wbeat(k, w, l0, b);
  endtask

  task automatic push_exp(input logic [7:0] e0, input logic [7:0] e1, input logic [7:0] e2);
    expq[0].push_back({4{e0}});
    expq[1].push_back({4{e1}});
    expq[2].push_back({4{e2}});
  endtask

  // Expected values in order: relu/round, none/truncate, leaky/round.
  task automatic run_vec(input logic [7:0] d, input logic [7:0] w, input logic [7:0] b, input bit l0,
                         input logic [7:0] e0, input logic [7:0] e1, input logic [7:0] e2);
    for (int g = 0; g < OUT_DEPTH; g++) push_exp(e0, e1, e2);
    send_vec(d);
    for (int g = 0; g < OUT_DEPTH; g++) send_group(w, l0, b);
  endtask

  initial begin
    rst = 1'b1;
    data_in_0 = '0; data_in_0_valid = 1'b0;
    weight = '0; weight_valid = 1'b0;
    bias = '0; bias_valid = 1'b0;
    out_rdy = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    for (int m = 0; m < NI; m++) begin
      chk($sformatf("rst_valid%0d", m), 32'(dval[m]), 0);
      chk($sformatf("rst_dout%0d", m), dout[m], 0);
    end
    chk("rst_din_rdy", 32'(drdy[0]), 0);
    chk("rst_w_rdy", 32'(wrdy[0]), 0);
    chk("rst_b_rdy", 32'(brdy[0]), 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk); #1;
    chk("din_rdy_after_rst", 32'(drdy[0]), 1);
    @(negedge clk);

    // 1.0 * 1.0 * 8 = 8.0 in every element
    run_vec(8'd8, 8'd8, 8'd0, 1'b0, 8'h40, 8'h40, 8'h40);
    chk("n_din_beats", nd, 2);
    chk("n_wt_beats", nw, 4);
    // -8.0: relu clamps, leaky gives -1.0
    run_vec(8'd8, 8'hF8, 8'd0, 1'b0, 8'h00, 8'hC0, 8'hF8);
    // positive saturation
    run_vec(8'd127, 8'd127, 8'd0, 1'b0, 8'h7F, 8'h7F, 8'h7F);
    // negative saturation; leaky of -128 is -16
    run_vec(8'd127, 8'h80, 8'd0, 1'b0, 8'h00, 8'h80, 8'hF0);
    // bias only: 1.5
    run_vec(8'd8, 8'd0, 8'd12, 1'b0, 8'h0C, 8'h0C, 8'h0C);
    // 0.0625: rounds up to one LSB, truncates to zero
    run_vec(8'd1, 8'd4, 8'd0, 1'b1, 8'h01, 8'h00, 8'h01);
    // 8.0 - 1.5 = 6.5
    run_vec(8'd8, 8'd8, 8'hF4, 1'b0, 8'h34, 8'h34, 8'h34);
    // -8.5: none -> -68, leaky floor(-68/8) = -9
    run_vec(8'd8, 8'hF8, 8'hFC, 1'b0, 8'h00, 8'hBC, 8'hF7);

    // Output back-pressure in EMIT, then bias stall on the last beat.
    push_exp(8'h40, 8'h40, 8'h40);
    push_exp(8'h40, 8'h40, 8'h40);
    send_vec(8'd8);
    send_wbeat(0, 8'd8, 1'b0, 8'd0);
    out_rdy = 1'b0;
    send_wbeat(1, 8'd8, 1'b0, 8'd0);
    weight = {16{8'd8}};
    weight_valid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      #1;
      chk("stall_valid", 32'(dval[0]), 1);
      chk("stall_data", dout[0], {4{8'h40}});
      chk("stall_w_rdy", 32'(wrdy[0]), 0);
      @(negedge clk);
    end
    out_rdy = 1'b1;
    send_wbeat(0, 8'd8, 1'b0, 8'd0);
    weight = {16{8'd8}};
    bias = '0;
    weight_valid = 1'b1;
    bias_valid = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1;
      chk("bias_stall_w_rdy", 32'(wrdy[0]), 0);
      chk("bias_stall_b_rdy", 32'(brdy[0]), 1);
      @(negedge clk);
    end
    send_wbeat(1, 8'd8, 1'b0, 8'd0);

    // Reset during the second group's accumulation drops that group.
    push_exp(8'h40, 8'h40, 8'h40);
    send_vec(8'd8);
    send_group(8'd8, 1'b0, 8'd0);
    send_wbeat(0, 8'd8, 1'b0, 8'd0);
    rst = 1'b1;
    #1;
    chk("midrst_valid", 32'(dval[0]), 0);
    chk("midrst_state", 32'(g_dut[0].u_dut.state_q), 32'(LOAD));
    chk("midrst_din_rdy", 32'(drdy[0]), 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk); #1;
    chk("din_rdy_after_midrst", 32'(drdy[0]), 1);
    @(negedge clk);
    run_vec(8'd8, 8'hF8, 8'd0, 1'b0, 8'h00, 8'hC0, 8'hF8);

    for (int n = 0; n < 100 && (expq[0].size() + expq[1].size() + expq[2].size()) != 0; n++)
      @(negedge clk);
    for (int m = 0; m < NI; m++)
      chk($sformatf("drain%0d", m), expq[m].size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
